sample_capture_buffer: RTL and testbench

SAMPLE_CAPTURE_BUFFER -- requirements
Module: sample_capture_buffer

---
 rtl/sample_capture_buffer.sv | 98 +++++++++
 tb/tb_sample_capture_buffer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sample_capture_buffer.sv
// Pre/post-trigger sample capture into a circular block-RAM buffer.
// Arm, fill PRETRIG samples, wait for trigger, then fill the rest of the buffer.
module sample_capture_buffer #(
  parameter int WORD_SIZE = 10,
  parameter int ADDR_W    = 10,
  parameter int PRETRIG   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 sample_valid,
  input  logic [WORD_SIZE-1:0] sample_in,
  input  logic                 trigger,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [WORD_SIZE-1:0] rd_data,
  output logic [ADDR_W-1:0]    start_addr,
  output logic                 busy,
  output logic                 done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   PRE_N  = (ADDR_W+1)'(PRETRIG);
  localparam logic [ADDR_W:0]   POST_N = (ADDR_W+1)'(DEPTH - PRETRIG);
  localparam logic [ADDR_W-1:0] PRE_A  = ADDR_W'(PRETRIG);

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;

  state_t               state;
  logic [ADDR_W-1:0]    wr_ptr;
  logic [ADDR_W:0]      cnt;
  logic [ADDR_W:0]      cnt_inc;
  logic                 we;
  logic [WORD_SIZE-1:0] mem [DEPTH];

  assign cnt_inc = cnt + 1'b1;
  // An arm cycle discards its strobe so the new capture starts cleanly at address 0.
  assign we = sample_valid && !arm && (state == PRE || state == ARMED || state == POST);

  // No reset on the array so it maps onto a simple dual-port RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wr_ptr] <= sample_in;
  end

  // Non-blocking read alongside the write gives read-first behaviour.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      cnt        <= '0;
      start_addr <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else if (arm) begin
      state      <= PRE;
      wr_ptr     <= '0;
      cnt        <= '0;
      start_addr <= '0;
      busy       <= 1'b1;
      done       <= 1'b0;
    end else begin
      case (state)
        PRE: if (sample_valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt    <= cnt_inc;
          if (cnt_inc == PRE_N) state <= ARMED;
        end
        ARMED: begin
          if (sample_valid) wr_ptr <= wr_ptr + 1'b1;
          if (trigger) begin
            // The trigger-cycle sample, if any, is post-trigger sample 0.
            state      <= POST;
            start_addr <= wr_ptr - PRE_A;
            cnt        <= {{ADDR_W{1'b0}}, sample_valid};
            if (sample_valid && POST_N == 1) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        POST: if (sample_valid) begin
          wr_ptr <= wr_ptr + 1'b1;
          cnt    <= cnt_inc;
          if (cnt_inc == POST_N) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_capture_buffer.sv
// Directed bench for sample_capture_buffer with a 16-deep buffer and 4 pre-trigger samples.
module tb_sample_capture_buffer;
  logic       clk = 1'b0;
  logic       rst, arm, sample_valid, trigger;
  logic [9:0] sample_in;
  logic [3:0] rd_addr;
  logic [9:0] rd_data;
  logic [3:0] start_addr;
  logic       busy, done;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [9:0] d;

  sample_capture_buffer #(.WORD_SIZE(10), .ADDR_W(4), .PRETRIG(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .sample_valid(sample_valid),
    .sample_in(sample_in), .trigger(trigger), .rd_addr(rd_addr),
    .rd_data(rd_data), .start_addr(start_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v, input logic trg);
    sample_valid = 1'b1;
    sample_in    = 10'(v);
    trigger      = trg;
    step();
    sample_valid = 1'b0;
    trigger      = 1'b0;
  endtask

  task automatic do_arm(input logic sv, input int v);
    arm          = 1'b1;
    sample_valid = sv;
    sample_in    = 10'(v);
    step();
    arm          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic rd(input int a, output logic [9:0] q);
    rd_addr = 4'(a);
    step();
    q = rd_data;
  endtask

  // Expect addresses first..first+15 (mod 16) to hold base, base+1, ...
  task automatic check_buf(input string tag, input int first, input int base);
    for (int i = 0; i < 16; i++) begin
      rd((first + i) % 16, d);
      chk(tag, d, base + i);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; sample_valid = 1'b0; trigger = 1'b0;
    sample_in = '0; rd_addr = '0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_start", start_addr, 0);
    chk("rst_rd_data", rd_data, 0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_busy", busy, 0);

    // Basic capture: trigger on sample 5, right after PRE completes.
    do_arm(1'b0, 0);
    chk("a_busy", busy, 1);
    chk("a_done", done, 0);
    for (int v = 1; v <= 4; v++) push(v, 1'b0);
    push(5, 1'b1);
    chk("a_start", start_addr, 0);
    for (int v = 6; v <= 15; v++) push(v, 1'b0);
    chk("a_done_early", done, 0);
    push(16, 1'b0);
    chk("a_done", done, 1);
    chk("a_busy_end", busy, 0);
    check_buf("a_buf", 0, 1);

    // DONE ignores further strobes and triggers.
    for (int v = 100; v < 105; v++) push(v, 1'b1);
    chk("d_done_hold", done, 1);
    chk("d_start_hold", start_addr, 0);
    check_buf("d_buf", 0, 1);
    rd_addr = 4'd3;
    #1;
    chk("d_rd_before_edge", rd_data, 16);
    step();
    chk("d_rd_latency", rd_data, 4);

    // Long ARMED phase with wraparound.
    do_arm(1'b0, 0);
    for (int v = 1; v <= 30; v++) push(v, 1'b0);
    push(31, 1'b1);
    chk("b_start", start_addr, 10);
    for (int v = 32; v <= 41; v++) push(v, 1'b0);
    chk("b_done_early", done, 0);
    push(42, 1'b0);
    chk("b_done", done, 1);
    check_buf("b_buf", 10, 27);

    // Trigger held during PRE is ignored; arm clears start_addr.
    do_arm(1'b0, 0);
    chk("c_start_cleared", start_addr, 0);
    for (int v = 1; v <= 4; v++) push(v, 1'b1);
    chk("c_busy_pre", busy, 1);
    chk("c_start_pre", start_addr, 0);
    chk("c_done_pre", done, 0);
    push(5, 1'b1);
    for (int v = 6; v <= 15; v++) push(v, 1'b0);
    chk("c_done_early", done, 0);
    push(16, 1'b0);
    chk("c_done", done, 1);
    check_buf("c_buf", 0, 1);

    // Reset during POST aborts; writes need a fresh arm.
    do_arm(1'b0, 0);
    for (int v = 1; v <= 6; v++) push(v, 1'b0);
    push(7, 1'b1);
    chk("e_start", start_addr, 2);
    for (int v = 8; v <= 12; v++) push(v, 1'b0);
    chk("e_busy_post", busy, 1);
    rst = 1'b1;
    #1;
    chk("e_rst_busy", busy, 0);
    chk("e_rst_done", done, 0);
    chk("e_rst_start", start_addr, 0);
    chk("e_rst_rd_data", rd_data, 0);
    step();
    rst = 1'b0;
    push(77, 1'b1);
    chk("e_idle_busy", busy, 0);
    rd(0, d);
    chk("e_ram_kept", d, 1);
    do_arm(1'b0, 0);
    for (int v = 100; v <= 103; v++) push(v, 1'b0);
    push(104, 1'b1);
    chk("e_restart_start", start_addr, 0);
    for (int v = 105; v <= 115; v++) push(v, 1'b0);
    chk("e_done", done, 1);
    check_buf("e_buf", 0, 100);

    // Re-arm while ARMED; the strobe in the arm cycle is dropped.
    do_arm(1'b0, 0);
    for (int v = 1; v <= 6; v++) push(v, 1'b0);
    do_arm(1'b1, 999);
    chk("f_busy", busy, 1);
    chk("f_start", start_addr, 0);
    for (int v = 201; v <= 204; v++) push(v, 1'b0);
    push(205, 1'b1);
    chk("f_trig_start", start_addr, 0);
    for (int v = 206; v <= 215; v++) push(v, 1'b0);
    chk("f_done_early", done, 0);
    push(216, 1'b0);
    chk("f_done", done, 1);
    check_buf("f_buf", 0, 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
